// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: data width, opcode
// field layout, opcode values and the 3-bit FSM state encodings.
package inst_fetch_unit_pkg;

  localparam int CPU_BIT_WIDTH = 32;
  localparam int OP_CODE_BITS  = 5;
  localparam int STATE_BITS    = 3;

  // Opcodes live in the top OP_CODE_BITS of the instruction word.
  localparam logic [OP_CODE_BITS-1:0] OP_NOP      = 5'd0;
  localparam logic [OP_CODE_BITS-1:0] OP_PUSH     = 5'd1;
  localparam logic [OP_CODE_BITS-1:0] OP_HALT     = 5'd31;
  localparam logic [OP_CODE_BITS-1:0] HALT_OPCODE = OP_HALT;

  localparam logic [STATE_BITS-1:0] S_IDLE       = 3'd0;
  localparam logic [STATE_BITS-1:0] S_LOAD       = 3'd1;
  localparam logic [STATE_BITS-1:0] S_PRESENT    = 3'd2;
  localparam logic [STATE_BITS-1:0] S_WAIT_DONE  = 3'd3;
  localparam logic [STATE_BITS-1:0] S_INVALIDATE = 3'd4;
  localparam logic [STATE_BITS-1:0] S_HALT       = 3'd5;

endpackage

// File: rtl/inst_fetch_unit_prog_rom.sv
// Program memory: one write port, one synchronous read port. Contents
// are deliberately not reset so a program survives a fetch-unit reset.
module prog_rom #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = inst_fetch_unit_pkg::CPU_BIT_WIDTH,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);
  import inst_fetch_unit_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write and registered read; the read register only updates when asked
  // so the fetched word stays put while the FSM inspects it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: hands instructions from program memory to a CPU
// over a level handshake (inst_ready / inst_complete), counts executed
// instructions and stops on the halt opcode or an out-of-range PC.
// Optional build macro: INST_FETCH_WATCHDOG_EN adds a timeout that halts
// the unit if the CPU stalls in PRESENT/WAIT_DONE for TIMEOUT_CYCLES.
module inst_fetch_unit #(
  parameter int CPU_BIT_WIDTH = inst_fetch_unit_pkg::CPU_BIT_WIDTH,
  parameter int PROG_DEPTH    = 256,
  parameter int ADDR_BITS     = 8,
  parameter logic [inst_fetch_unit_pkg::OP_CODE_BITS-1:0] HALT_OPCODE =
    inst_fetch_unit_pkg::HALT_OPCODE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     run_i,
  input  logic                     prog_we_i,
  input  logic [ADDR_BITS-1:0]     prog_addr_i,
  input  logic [CPU_BIT_WIDTH-1:0] prog_data_i,
  input  logic [CPU_BIT_WIDTH-1:0] pc_next_i,
  input  logic                     inst_complete_i,
  output logic [CPU_BIT_WIDTH-1:0] inst_o,
  output logic                     inst_ready_o,
  output logic                     halted_o,
  output logic [CPU_BIT_WIDTH-1:0] inst_count_o
);
  import inst_fetch_unit_pkg::*;

  logic [STATE_BITS-1:0]    state_q, state_d;
  logic                     ph_q, ph_d;        // LOAD sub-phase: 0 = issue read, 1 = use data
  logic [CPU_BIT_WIDTH-1:0] inst_q, inst_d;
  logic                     rdy_q, rdy_d;
  logic                     halted_q, halted_d;
  logic [CPU_BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CPU_BIT_WIDTH-1:0] rom_rdata;
  logic                     rom_we, rom_re, pc_oob;
  logic [OP_CODE_BITS-1:0]  opcode;

  // Writes only while paused or halted, so they can never collide with a
  // fetch read. The read fires once, in the first LOAD cycle.
  assign rom_we = prog_we_i && (state_q == S_IDLE || state_q == S_HALT);
  assign rom_re = (state_q == S_LOAD) && !ph_q;
  assign pc_oob = pc_next_i >= CPU_BIT_WIDTH'(PROG_DEPTH);
  assign opcode = rom_rdata[CPU_BIT_WIDTH-1 -: OP_CODE_BITS];

  prog_rom #(
    .DEPTH    (PROG_DEPTH),
    .WIDTH    (CPU_BIT_WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_rom (
    .clk_i  (clk_i),
    .we_i   (rom_we),
    .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i),
    .re_i   (rom_re),
    .raddr_i(pc_next_i[ADDR_BITS-1:0]),
    .rdata_o(rom_rdata)
  );

`ifdef INST_FETCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Next-state, output and counter logic for the fetch handshake.
  always_comb begin
    state_d  = state_q;
    ph_d     = 1'b0;
    inst_d   = inst_q;
    rdy_d    = rdy_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b0;
        if (run_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!ph_q) begin
          if (pc_oob) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            ph_d = 1'b1;
          end
        end else if (opcode == HALT_OPCODE) begin
          // Halt word is never presented nor counted.
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          inst_d  = rom_rdata;
          rdy_d   = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // A leftover high complete from the previous instruction is ignored
        // until the CPU shows acceptance by dropping it.
        if (!inst_complete_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (inst_complete_i) begin
          state_d = S_INVALIDATE;
          rdy_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_INVALIDATE: begin
        state_d = run_i ? S_LOAD : S_IDLE;
      end
      S_HALT: begin
        halted_d = 1'b1;
        rdy_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b0;
      end
    endcase
`ifdef INST_FETCH_WATCHDOG_EN
    // Stalled CPU: give up once the limit is reached with no progress.
    if ((state_q == S_PRESENT || state_q == S_WAIT_DONE) && state_d == state_q &&
        wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d  = S_HALT;
      halted_d = 1'b1;
      rdy_d    = 1'b0;
    end
    if (state_d != state_q)
      wd_d = '0;
    else if (state_q == S_PRESENT || state_q == S_WAIT_DONE)
      wd_d = wd_q + 1'b1;
    else
      wd_d = '0;
`endif
  end

  // State and output registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      inst_q   <= '0;
      rdy_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      inst_q   <= inst_d;
      rdy_q    <= rdy_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef INST_FETCH_WATCHDOG_EN
  // Watchdog counter register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`endif

  assign inst_o       = inst_q;
  assign inst_ready_o = rdy_q;
  assign halted_o     = halted_q;
  assign inst_count_o = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a reference program image and a
// scoreboard of expected instruction words, consumed as the DUT presents them.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, run, prog_we, inst_complete;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data, pc_next;
  logic [31:0] inst, inst_count;
  logic        inst_ready, halted;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model_rom [256];
  logic [31:0] exp_q [$];

  inst_fetch_unit #(
    .CPU_BIT_WIDTH (32),
    .PROG_DEPTH    (256),
    .ADDR_BITS     (8),
    .HALT_OPCODE   (5'd31),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .run_i          (run),
    .prog_we_i      (prog_we),
    .prog_addr_i    (prog_addr),
    .prog_data_i    (prog_data),
    .pc_next_i      (pc_next),
    .inst_complete_i(inst_complete),
    .inst_o         (inst),
    .inst_ready_o   (inst_ready),
    .halted_o       (halted),
    .inst_count_o   (inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rom_write(input logic [7:0] a, input logic [31:0] d, input bit accepted);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    if (accepted) model_rom[a] = d;
  endtask

  // Wait (bounded) for inst_ready, then compare against the scoreboard head.
  task automatic expect_inst(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (inst_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else chk(tag, inst, exp_q.pop_front());
  endtask

  task automatic wait_halted(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (halted) begin ok = 1; break; end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_inst"},  inst,        32'd0);
    chk({tag, "_rdy"},   32'(inst_ready), 32'd0);
    chk({tag, "_halt"},  32'(halted), 32'd0);
    chk({tag, "_cnt"},   inst_count,  32'd0);
  endtask

  initial begin
    int low, highs;
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    pc_next = '0; inst_complete = 1'b1;
    for (int i = 0; i < 256; i++) model_rom[i] = '0;
    tick();
    chk_zero_outputs("reset");
    tick();
    reset = 1'b0;

    // Program image while idle.
    rom_write(8'd0, 32'h0800_0005, 1);  // push 5
    rom_write(8'd1, 32'hF800_0000, 1);  // halt
    rom_write(8'd2, 32'h1000_0002, 1);
    rom_write(8'd3, 32'h0800_000A, 1);
    rom_write(8'd5, 32'h2800_0055, 1);

    // Instruction 0; complete starts high and must be ignored.
    pc_next = 32'd0; exp_q.push_back(model_rom[0]); run = 1'b1;
    expect_inst("inst_rom0");
    repeat (3) tick();
    chk("hold_rdy", 32'(inst_ready), 32'd1);
    chk("cnt_before", inst_count, 32'd0);
    rom_write(8'd5, 32'hDEAD_BEEF, 0);  // busy: must be dropped
    inst_complete = 1'b0; tick(); tick();
    chk("accept_rdy", 32'(inst_ready), 32'd1);
    chk("accept_inst", inst, 32'h0800_0005);
    inst_complete = 1'b1; pc_next = 32'd3; exp_q.push_back(model_rom[3]);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (inst_ready) break;
      low++;
    end
    chk("gap_ge3", 32'(low >= 3), 32'd1);
    expect_inst("inst_rom3");
    chk("cnt1", inst_count, 32'd1);

    // Drop run mid-instruction: it completes, then the unit parks.
    inst_complete = 1'b0; tick();
    run = 1'b0; tick();
    inst_complete = 1'b1; pc_next = 32'd2;
    highs = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (inst_ready) highs++; end
    chk("park_rdy", 32'(highs), 32'd0);
    chk("cnt2", inst_count, 32'd2);
    rom_write(8'd2, 32'h1800_0003, 1);  // parked: accepted
    exp_q.push_back(model_rom[2]); run = 1'b1;
    expect_inst("inst_rom2_resume");

    // Next PC hits the halt word.
    inst_complete = 1'b0; tick(); tick();
    inst_complete = 1'b1; pc_next = 32'd1;
    wait_halted("halt_word");
    repeat (4) tick();
    chk("halt_hold", 32'(halted), 32'd1);
    chk("halt_rdy", 32'(inst_ready), 32'd0);
    chk("halt_cnt", inst_count, 32'd3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset, then check the busy-time write never landed.
    reset = 1'b1; pc_next = 32'd5; tick();
    reset = 1'b0; exp_q.push_back(model_rom[5]);
    expect_inst("inst_rom5");
    inst_complete = 1'b0; tick(); tick();
    #2 reset = 1'b1;
    #1 chk_zero_outputs("rst_wait");
    tick();
    inst_complete = 1'b1; pc_next = 32'd0; exp_q.push_back(model_rom[0]);
    reset = 1'b0;
    expect_inst("inst_rom0_retained");

    // Out-of-range PC: halt without ever presenting.
    inst_complete = 1'b0; tick(); tick();
    inst_complete = 1'b1; pc_next = 32'd300;
    highs = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (inst_ready) highs++; end
    chk("oob_halt", 32'(halted), 32'd1);
    chk("oob_rdy", 32'(highs), 32'd0);
    chk("oob_cnt", inst_count, 32'd1);

`ifdef INST_FETCH_WATCHDOG_EN
    // CPU never accepts: watchdog halts after TIMEOUT_CYCLES in PRESENT.
    reset = 1'b1; pc_next = 32'd0; tick();
    reset = 1'b0; exp_q.push_back(model_rom[0]);
    expect_inst("wd_inst");
    low = 0;
    while (!halted && low < 100) begin tick(); low++; end
    chk("wd_cycles", 32'(low), 32'd16);
    chk("wd_rdy", 32'(inst_ready), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
